// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the RV32I immediate encoder: format codes,
// the NOP word emitted for illegal formats, and per-format immediate limits.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100,
        IMM_R = 3'b111
    } immsrc_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic signed [31:0] I_MIN = -32'sd2048;
    localparam logic signed [31:0] I_MAX = 32'sd2047;
    localparam logic signed [31:0] B_MIN = -32'sd4096;
    localparam logic signed [31:0] B_MAX = 32'sd4094;
    localparam logic signed [31:0] J_MIN = -32'sd1048576;
    localparam logic signed [31:0] J_MAX = 32'sd1048574;

    function automatic logic out_of_range(input logic signed [31:0] v,
                                          input logic signed [31:0] lo,
                                          input logic signed [31:0] hi);
        return (v < lo) || (v > hi);
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Field-bundle input and instruction-memory write stream of the immediate encoder.
// master = loader side driving fields, slave = the encoder.
interface imm_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_immsrc;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_instr;

    modport master (
        output in_valid, in_immsrc, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_addr, out_instr
    );

    modport slave (
        input  in_valid, in_immsrc, in_opcode, in_rd, in_rs1, in_rs2,
               in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_addr, out_instr
    );
endinterface

// File: rtl/imm_encoder_pack.sv
// Combinational scatter of a 32-bit immediate and register fields into an
// RV32I instruction word, plus the per-format range/alignment check.
module imm_pack
    import imm_pkg::*;
(
    input  logic [2:0]  immsrc_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        range_err_o
);
    immsrc_t            src;
    logic signed [31:0] imm_s;

    assign src   = immsrc_t'(immsrc_i);
    assign imm_s = $signed(imm_i);

    always_comb begin
        instr_o     = NOP;
        range_err_o = 1'b0;
        case (src)
            IMM_I: begin
                instr_o     = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                range_err_o = out_of_range(imm_s, I_MIN, I_MAX);
            end
            IMM_S: begin
                instr_o     = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                range_err_o = out_of_range(imm_s, I_MIN, I_MAX);
            end
            IMM_B: begin
                instr_o     = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], opcode_i};
                range_err_o = out_of_range(imm_s, B_MIN, B_MAX) || imm_i[0];
            end
            IMM_U: begin
                instr_o     = {imm_i[31:12], rd_i, opcode_i};
                range_err_o = (imm_i[11:0] != 12'h000);
            end
            IMM_J: begin
                instr_o     = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                range_err_o = out_of_range(imm_s, J_MIN, J_MAX) || imm_i[0];
            end
            IMM_R: begin
                instr_o     = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            default: begin
                range_err_o = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder emitting a sequentially addressed
// instruction-memory write stream. Optional macro: ROUNDTRIP_CHECK_EN.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                base_load,
    input  logic [ADDR_W-1:0]   base_addr,
    imm_encoder_if.slave        bus,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count
`ifdef ROUNDTRIP_CHECK_EN
    ,
    output logic                rt_mismatch
`endif
);
    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_immsrc_q;
    logic [6:0]  s1_opcode_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_funct3_q;
    logic [6:0]  s1_funct7_q;
    logic [31:0] s1_imm_q;

    logic [31:0] s1_instr;
    logic        s1_err;
    logic        accept;
    logic        advance;

    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic                s2_valid_q, s2_valid_d;
    logic [31:0]         out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic                err_q, err_d;
    logic [ERRCNT_W-1:0] err_count_q, err_count_d;

    assign advance      = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign bus.in_ready = !s1_valid_q || advance;
    assign accept       = bus.in_valid && bus.in_ready;

    imm_pack u_pack (
        .immsrc_i    (s1_immsrc_q),
        .opcode_i    (s1_opcode_q),
        .rd_i        (s1_rd_q),
        .rs1_i       (s1_rs1_q),
        .rs2_i       (s1_rs2_q),
        .funct3_i    (s1_funct3_q),
        .funct7_i    (s1_funct7_q),
        .imm_i       (s1_imm_q),
        .instr_o     (s1_instr),
        .range_err_o (s1_err)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        addr_cnt_d  = addr_cnt_q;
        s2_valid_d  = s2_valid_q;
        out_instr_d = out_instr_q;
        out_addr_d  = out_addr_q;
        err_d       = err_q;
        err_count_d = err_count_q;

        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        // A load wins over the increment; the word advancing this cycle keeps the old address.
        if (base_load) begin
            addr_cnt_d = {base_addr[ADDR_W-1:2], 2'b00};
        end else if (advance && !reset) begin
            addr_cnt_d = addr_cnt_q + ADDR_W'(4);
        end

        if (advance) begin
            s2_valid_d  = 1'b1;
            out_instr_d = s1_instr;
            out_addr_d  = addr_cnt_q;
            if (s1_err) begin
                err_d = 1'b1;
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + ERRCNT_W'(1);
                end
            end
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_instr_q <= '0;
            out_addr_q  <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_instr_q <= out_instr_d;
            out_addr_q  <= out_addr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // NOTE: the counter and the S1 payload are not reset: the counter must keep a base
    // loaded just before reset, and the payload is qualified by s1_valid_q.
    always_ff @(posedge clk) begin
        addr_cnt_q <= addr_cnt_d;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_immsrc_q <= bus.in_immsrc;
            s1_opcode_q <= bus.in_opcode;
            s1_rd_q     <= bus.in_rd;
            s1_rs1_q    <= bus.in_rs1;
            s1_rs2_q    <= bus.in_rs2;
            s1_funct3_q <= bus.in_funct3;
            s1_funct7_q <= bus.in_funct7;
            s1_imm_q    <= bus.in_imm;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign err           = err_q;
    assign err_count     = err_count_q;

`ifdef ROUNDTRIP_CHECK_EN
    immsrc_t     s2_src_q;
    logic [31:0] s2_imm_q;
    logic        s2_flag_q;
    logic [31:0] rt_imm;
    logic        rt_q, rt_d;

    always_ff @(posedge clk) begin
        if (advance) begin
            s2_src_q  <= immsrc_t'(s1_immsrc_q);
            s2_imm_q  <= s1_imm_q;
            s2_flag_q <= s1_err;
        end
    end

    // Same sign-extension rules as the decode-stage extender; R and illegal never compare.
    always_comb begin
        rt_imm = s2_imm_q;
        case (s2_src_q)
            IMM_I: rt_imm = {{20{out_instr_q[31]}}, out_instr_q[31:20]};
            IMM_S: rt_imm = {{20{out_instr_q[31]}}, out_instr_q[31:25], out_instr_q[11:7]};
            IMM_B: rt_imm = {{19{out_instr_q[31]}}, out_instr_q[31], out_instr_q[7],
                             out_instr_q[30:25], out_instr_q[11:8], 1'b0};
            IMM_U: rt_imm = {out_instr_q[31:12], 12'h000};
            IMM_J: rt_imm = {{11{out_instr_q[31]}}, out_instr_q[31], out_instr_q[19:12],
                             out_instr_q[20], out_instr_q[30:21], 1'b0};
            default: rt_imm = s2_imm_q;
        endcase
        rt_d = rt_q || (s2_valid_q && !s2_flag_q && (rt_imm != s2_imm_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rt_q <= 1'b0;
        end else begin
            rt_q <= rt_d;
        end
    end

    assign rt_mismatch = rt_q;
`endif
endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the decode-stage immediate extender. Accepts instruction fields plus a full 32-bit immediate, range-checks the immediate, scatters its bits into the RISC-V I/S/B/U/J (or R) format and emits the 32-bit instruction word.
- Output is a sequentially addressed instruction-memory write stream.
- Used by the program loader / self-test path to build RV32I programs in hardware.
- Two-stage valid/ready pipeline with an address counter and error accounting.

Parameters:
- ADDR_W, 32, width of out_addr / base_addr.
- ERRCNT_W, 8, width of saturating error counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- base_load  in  1  load address counter from base_addr
- base_addr  in  ADDR_W  start address, must be word-aligned
- in_valid  in  1  input field bundle valid
- in_ready  out  1  encoder can accept
- in_immsrc  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 111 R
- in_opcode  in  7  opcode
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7 (R only)
- in_imm  in  32  sign-extended byte-offset immediate (U: full value, low 12 bits zero)
- out_valid  out  1  word valid
- out_ready  in  1  memory accepts
- out_addr  out  ADDR_W  write address
- out_instr  out  32  encoded instruction
- err  out  1  sticky range/format error
- err_count  out  ERRCNT_W  saturating count of bad inputs

Behaviour:
- Reset (synchronous, active-high, clk rising edge):
  - both stage valids 0; in_ready=1; out_valid=0
  - out_addr=0, out_instr=0, err=0, err_count=0
- Stage 1 (S1): register fields on an in_valid&&in_ready transfer. Compute the packed word and range flag combinationally from the S1 registers.
- Stage 2 (S2): output register.
  - S1→S2 advance when S1 valid and (S2 empty or out_ready).
  - in_ready = !S1valid || advance. This is a full-throughput pipeline: 1 word/cycle at 2-cycle latency from in_valid accept to out_valid.
- Address counter:
  - out_addr captured into S2 on advance.
  - Counter +4 on each S1→S2 advance; wraps modulo 2^ADDR_W.
  - base_load has priority over increment in the same cycle. Loaded value applies to the next advancing word.
  - base_load with a non-aligned address: low 2 bits forced to 0.
- Packing, standard RV32I bit positions:
  - I: imm[11:0]→[31:20]
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7]
  - B: imm[12],imm[10:5]→[31:25]; imm[4:1],imm[11]→[11:7]
  - U: imm[31:12]→[31:12]
  - J: imm[20],imm[10:1],imm[11],imm[19:12]→[31:12]
  - R: funct7→[31:25], imm ignored
  - Fields not used by a format are driven 0: rd for S/B, rs1/rs2/funct3 for U/J, rs2 for I.
- Range errors:
  - I/S: imm outside [-2048, 2047]
  - B: outside [-4096, 4094] or imm[0]=1
  - J: outside [-2^20, 2^20-2] or imm[0]=1
  - U: imm[11:0]≠0
  - immsrc 101/110: illegal format
- On error:
  - the word is still emitted, truncated (illegal format emits 0x00000013, NOP); address still advances
  - err set sticky until reset
  - err_count +1, saturating at all-ones
- Error accounting happens on S1→S2 advance, exactly once per word, even if the word stalls in S2.
- S2 holds out_instr/out_addr stable while out_valid && !out_ready.
- Reset mid-stream discards both stages; no partial word is emitted.

Optional Feature:
- ROUNDTRIP_CHECK_EN defined:
  - S2 re-decodes out_instr's immediate with the same format rules as the decode stage.
  - Compares the result against the S1 imm, which is held alongside S2.
  - A mismatch on a word not already flagged asserts extra output rt_mismatch (sticky, 1 bit).
- Undefined: port rt_mismatch is absent and no compare logic exists.

Decomposition:
- Shared package imm_pkg:
  - immsrc_t enum (IMM_I=3'b000, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R=3'b111)
  - NOP constant 32'h00000013
  - per-format min/max limit constants
- One sub-module, imm_pack (combinational field scatter + range check), instantiated once in S1. The roundtrip decoder lives in the top under the macro.

Test Plan:
- I-type addi x1,x0,5 (op 0010011, f3 0, imm 5), base 0 → out_instr 0x00500093 at out_addr 0, two cycles after accept, err=0.
- S-type sw x2,8(x1) (op 0100011, f3 010) then B-type beq x0,x0,-4 (op 1100011) back-to-back:
  - 0x0020A423 @0
  - 0xFE000EE3 @4
  - consecutive cycles
- U-type lui x5,0x12345000 → 0x123452B7; J-type jal x1,2048 (op 1101111) → 0x001000EF; err stays 0.
- I-type imm=2048 → err=1, err_count=1. Illegal immsrc 101 → out_instr 0x00000013, err_count=2. Stalling that word does not recount.
- out_ready held low, push 3 words:
  - in_ready drops after 2 accepts
  - on release, words drain in order at addrs 0,4,8 with no loss or duplication
- Mid-stream base_load 0x100 together with an advance, then reset → next word at 0x100; after reset, out_valid=0, err=0, out_addr=0.
